// File: rtl/byte_bus_responder_pkg.sv
// Shared constants for the byte bus responder: I/O offsets and STATUS bit layout.
// Included by the top level and by its FIFO sub-module.
package byte_bus_responder_pkg;

    localparam logic [2:0] IO_DATA_OFF = 3'h0;
    localparam logic [2:0] IO_STAT_OFF = 3'h4;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_RX_NONEMPTY = 1;
    localparam int ST_OVERFLOW    = 2;

    function automatic logic [7:0] status_byte(input logic overflow,
                                               input logic rx_nonempty,
                                               input logic tx_full);
        logic [7:0] s;
        s = '0;
        s[ST_TX_FULL]     = tx_full;
        s[ST_RX_NONEMPTY] = rx_nonempty;
        s[ST_OVERFLOW]    = overflow;
        return s;
    endfunction

endpackage

// File: rtl/byte_bus_responder_byte_fifo.sv
// Byte FIFO, 2^AW entries. A push into a full FIFO is accepted only when a pop
// happens on the same edge. dout reads 0 while empty.
module byte_fifo
    import byte_bus_responder_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  din,
    output logic        full,
    input  logic        pop,
    output logic [7:0]  dout,
    output logic        empty,
    output logic [AW:0] count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem [0:DEPTH-1];
    logic [AW-1:0] rptr_reg;
    logic [AW-1:0] wptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? 8'h00 : mem[rptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_pop)  rptr_reg <= rptr_reg + AW'(1);
            if (do_push) wptr_reg <= wptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    // Storage is not reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push & ~rst) mem[wptr_reg] <= din;
    end

endmodule

// File: rtl/byte_bus_responder.sv
// Bus target for the CPU byte bus: decodes each cycle to on-chip byte RAM or the
// I/O region (TX/RX console FIFOs, STATUS, SIM_END). Registered read data, no stalls.
module byte_bus_responder
    import byte_bus_responder_pkg::*;
#(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] bus_a,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wr,
    output logic [7:0]  bus_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_end,
    output logic [7:0]  end_code
);

    logic [7:0]        ram [0:(1 << RAM_AW)-1];
    logic [7:0]        ram_q;
    logic [RAM_AW-1:0] ram_addr;

    logic       io_sel;
    logic [2:0] io_off;
    logic       wr_cycle;
    logic       rd_cycle;
    logic       ram_we;
    logic       ram_re;

    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic [FIFO_AW:0] tx_count, rx_count;

    logic       rd_io_reg;
    logic [7:0] io_rdata_reg;
    logic [7:0] io_rdata_next;
    logic       overflow_reg;
    logic       sim_end_reg;
    logic [7:0] end_code_reg;
    logic       stat_wr;
    logic       tx_drop;
    logic       unused;

    assign io_sel   = bus_a[RAM_AW];
    assign io_off   = bus_a[2:0];
    assign ram_addr = bus_a[RAM_AW-1:0];
    assign wr_cycle = rdy & bus_wr;
    assign rd_cycle = rdy & ~bus_wr;
    assign ram_we   = wr_cycle & ~io_sel & ~rst;
    assign ram_re   = rd_cycle & ~io_sel;

    assign tx_push  = wr_cycle & io_sel & (io_off == IO_DATA_OFF);
    assign tx_pop   = ~tx_empty & tx_ready;
    assign tx_drop  = tx_push & tx_full & ~tx_pop;
    assign rx_push  = rx_valid & ~rx_full;
    assign rx_pop   = rd_cycle & io_sel & (io_off == IO_DATA_OFF) & ~rx_empty;
    assign stat_wr  = wr_cycle & io_sel & (io_off == IO_STAT_OFF);

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;
    assign sim_end  = sim_end_reg;
    assign end_code = end_code_reg;
    assign unused   = ^{bus_a[31:RAM_AW+1], tx_count, rx_count};

    byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push(tx_push), .din(bus_wdata), .full(tx_full),
        .pop(tx_pop), .dout(tx_data), .empty(tx_empty),
        .count(tx_count)
    );

    byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push(rx_push), .din(rx_data), .full(rx_full),
        .pop(rx_pop), .dout(rx_head), .empty(rx_empty),
        .count(rx_count)
    );

    always_comb begin
        io_rdata_next = 8'h00;
        case (io_off)
            IO_DATA_OFF: io_rdata_next = rx_head;
            IO_STAT_OFF: io_rdata_next = status_byte(overflow_reg, ~rx_empty, tx_full);
            default:     io_rdata_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= bus_wdata;
        if (ram_re) ram_q <= ram[ram_addr];
    end

    // Read data source is latched per read cycle; selecting the I/O byte out of
    // reset gives bus_rdata=0 without touching the unreset RAM output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_io_reg    <= 1'b1;
            io_rdata_reg <= 8'h00;
            overflow_reg <= 1'b0;
            sim_end_reg  <= 1'b0;
            end_code_reg <= 8'h00;
        end else begin
            if (rd_cycle) begin
                rd_io_reg <= io_sel;
                if (io_sel) io_rdata_reg <= io_rdata_next;
            end
            if (tx_drop) overflow_reg <= 1'b1;
            if (stat_wr) begin
                sim_end_reg  <= 1'b1;
                end_code_reg <= bus_wdata;
            end
        end
    end

    assign bus_rdata = rd_io_reg ? io_rdata_reg : ram_q;

endmodule

// File: tb/tb_byte_bus_responder.sv
// Randomized and directed bench for byte_bus_responder against a queue-based
// transaction model of the RAM, the two FIFOs and the status/sim-end registers.
module tb_byte_bus_responder;

    localparam logic [31:0] IO   = 32'h0002_0000;
    localparam logic [31:0] STAT = 32'h0002_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic [31:0] bus_a = '0;
    logic [7:0]  bus_wdata = '0;
    logic        bus_wr = 1'b0;
    logic [7:0]  bus_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        sim_end;
    logic [7:0]  end_code;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Reference model state
    logic [7:0] m_ram [int];
    logic [7:0] m_txq [$];
    logic [7:0] m_rxq [$];
    logic       m_ovf = 1'b0;
    logic       m_end = 1'b0;
    logic [7:0] m_code = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    bit         m_known = 1'b1;

    byte_bus_responder dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .bus_a(bus_a), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rdata(bus_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .sim_end(sim_end), .end_code(end_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    task automatic check_outputs();
        if (m_known) check("rdata", {24'h0, bus_rdata}, {24'h0, m_rdata});
        check("tx_valid", {31'h0, tx_valid}, {31'h0, m_txq.size() > 0});
        check("tx_data", {24'h0, tx_data}, {24'h0, (m_txq.size() > 0) ? m_txq[0] : 8'h00});
        check("rx_ready", {31'h0, rx_ready}, {31'h0, m_rxq.size() < 16});
        check("sim_end", {31'h0, sim_end}, {31'h0, m_end});
        check("end_code", {24'h0, end_code}, {24'h0, m_code});
    endtask

    task automatic model_reset();
        m_txq.delete();
        m_rxq.delete();
        m_ovf = 1'b0; m_end = 1'b0; m_code = 8'h00;
        m_rdata = 8'h00; m_known = 1'b1;
    endtask

    // One clock: update the model from the inputs presented now, then clock and compare.
    task automatic step();
        int  tsz, rsz, addr;
        bit  io, tpop, rpush, rpop;
        logic [2:0] off;
        tsz   = m_txq.size();
        rsz   = m_rxq.size();
        io    = bus_a[17];
        off   = bus_a[2:0];
        addr  = int'(bus_a[16:0]);
        tpop  = tx_ready && tsz > 0;
        rpush = rx_valid && rsz < 16;
        rpop  = rdy && !bus_wr && io && off == 3'd0 && rsz > 0;
        if (tpop) void'(m_txq.pop_front());
        if (rdy && bus_wr) begin
            if (io && off == 3'd0) begin
                if (tsz < 16 || tpop) m_txq.push_back(bus_wdata);
                else m_ovf = 1'b1;
            end else if (io && off == 3'd4) begin
                m_end = 1'b1; m_code = bus_wdata;
            end else if (!io) begin
                m_ram[addr] = bus_wdata;
            end
        end else if (rdy) begin
            m_known = 1'b1;
            if (io) begin
                if (off == 3'd0)      m_rdata = (rsz > 0) ? m_rxq[0] : 8'h00;
                else if (off == 3'd4) m_rdata = {5'b0, m_ovf, rsz > 0, tsz == 16};
                else                  m_rdata = 8'h00;
            end else if (m_ram.exists(addr)) begin
                m_rdata = m_ram[addr];
            end else begin
                m_known = 1'b0;
            end
        end
        if (rpop)  void'(m_rxq.pop_front());
        if (rpush) m_rxq.push_back(rx_data);
        @(posedge clk);
        #1;
        cyc_n++;
        $display("cyc %0d rdy=%0b wr=%0b a=%08h wd=%02h rd=%02h tx=%0b/%02h rxr=%0b end=%0b/%02h",
                 cyc_n, rdy, bus_wr, bus_a, bus_wdata, bus_rdata, tx_valid, tx_data,
                 rx_ready, sim_end, end_code);
        check_outputs();
    endtask

    task automatic bus(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d);
        rdy = r; bus_a = a; bus_wr = w; bus_wdata = d;
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // RAM write then read, one-clock latency
        bus(1, 32'h10, 1, 8'hA5);
        bus(1, 32'h10, 0, 8'h00);
        check("t1 ram", {24'h0, bus_rdata}, 32'hA5);

        // Back-to-back burst read
        for (int i = 0; i < 4; i++) bus(1, 32'h100 + i, 1, 8'(8'h11 * (i + 1)));
        for (int i = 0; i < 4; i++) begin
            bus(1, 32'h100 + i, 0, 8'h00);
            check("t2 burst", {24'h0, bus_rdata}, 32'(8'h11 * (i + 1)));
        end

        // TX overflow and drain
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) bus(1, IO, 1, 8'(8'h30 + i));
        bus(1, STAT, 0, 8'h00);
        check("t3 status", {24'h0, bus_rdata}, 32'h05);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3 drain", {24'h0, tx_data}, 32'(8'h30 + i));
            bus(0, 32'h0, 0, 8'h00);
        end
        check("t3 empty", {31'h0, tx_valid}, 32'h0);

        // RX path
        bus(1, IO, 0, 8'h00);
        check("t4 rx empty", {24'h0, bus_rdata}, 32'h00);
        rx_data = 8'h41; rx_valid = 1'b1;
        bus(0, 32'h0, 0, 8'h00);
        rx_valid = 1'b0;
        bus(1, STAT, 0, 8'h00);
        check("t4 rx_ne", {31'h0, bus_rdata[1]}, 32'h1);
        bus(1, IO, 0, 8'h00);
        check("t4 rx data", {24'h0, bus_rdata}, 32'h41);
        bus(1, STAT, 0, 8'h00);
        check("t4 rx_ne clr", {31'h0, bus_rdata[1]}, 32'h0);

        // rdy=0 freezes the bus side
        bus(1, 32'h20, 1, 8'h11);
        bus(1, 32'h10, 0, 8'h00);
        bus(0, 32'h20, 1, 8'h99);
        check("t5 hold", {24'h0, bus_rdata}, 32'hA5);
        bus(1, 32'h20, 0, 8'h00);
        check("t5 unchanged", {24'h0, bus_rdata}, 32'h11);
        bus(1, 32'h20, 1, 8'h99);
        bus(1, 32'h20, 0, 8'h00);
        check("t5 landed", {24'h0, bus_rdata}, 32'h99);

        // SIM_END and asynchronous reset mid-burst
        bus(1, STAT, 1, 8'h03);
        check("t6 sim_end", {31'h0, sim_end}, 32'h1);
        check("t6 end_code", {24'h0, end_code}, 32'h03);
        tx_ready = 1'b0;
        bus(1, IO, 1, 8'h77);
        bus(1, 32'h100, 0, 8'h00);
        bus(1, 32'h101, 0, 8'h00);
        bus_a = 32'h102;
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("t6 rst rdata", {24'h0, bus_rdata}, 32'h00);
        check("t6 rst sim_end", {31'h0, sim_end}, 32'h0);
        check("t6 rst tx_valid", {31'h0, tx_valid}, 32'h0);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        bus(1, 32'h10, 0, 8'h00);
        check("t6 ram kept", {24'h0, bus_rdata}, 32'hA5);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                a[17] = 1'b1;
                a[2:0] = ($urandom_range(0, 3) == 0) ? 3'(($urandom_range(0, 7))) :
                         (($urandom_range(0, 2) == 0) ? 3'd4 : 3'd0);
            end else begin
                a[17] = 1'b0;
                a[16:0] = 17'($urandom_range(0, 63));
            end
            tx_ready = (i < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            rx_valid = (i < 300) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0);
            rx_data  = 8'($urandom);
            bus($urandom_range(0, 4) != 0, a, $urandom_range(0, 1) == 1, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
